// File: rtl/tile_stream_writer_if.sv
// tile_stream_writer_if: SRAM write-port bundle between writer and arbiter.
// Ports: sramWrReq/sramWrAddr/sramWrData (master out), sramWrAck (master in).
interface tile_stream_writer_if #(
    parameter int ADDR_W = 20
);
    logic              sramWrReq;
    logic [ADDR_W-1:0] sramWrAddr;
    logic [15:0]       sramWrData;
    logic              sramWrAck;

    modport master (
        output sramWrReq,
        output sramWrAddr,
        output sramWrData,
        input  sramWrAck
    );

    modport slave (
        input  sramWrReq,
        input  sramWrAddr,
        input  sramWrData,
        output sramWrAck
    );
endinterface

// File: rtl/tile_stream_writer.sv
// tile_stream_writer: streams one TILE_DIM x TILE_DIM tile of 16-bit pixels
// from the on-chip tile buffer into the SRAM framebuffer, row-major.
// Ports: BOARD_CLK, Reset_n (async, active-low); startStreaming/tileID/
//   xOffset/yOffset from the scheduler, doneStreaming back to it;
//   tileRdSel/tileRdX/tileRdY out and tileRdData in (1-cycle read latency);
//   sramBus (master modport) carries the req/addr/data/ack write port.
// Build option: define TILE_CLIP_EN to skip pixels outside the screen.
module tile_stream_writer #(
    parameter int TILE_DIM = 32,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int ADDR_W   = 20
) (
    input  logic                        BOARD_CLK,
    input  logic                        Reset_n,
    input  logic                        startStreaming,
    input  logic                        tileID,
    input  logic [9:0]                  xOffset,
    input  logic [9:0]                  yOffset,
    output logic                        doneStreaming,
    output logic                        tileRdSel,
    output logic [$clog2(TILE_DIM)-1:0] tileRdX,
    output logic [$clog2(TILE_DIM)-1:0] tileRdY,
    input  logic [15:0]                 tileRdData,
    tile_stream_writer_if.master        sramBus
);
    localparam int LOG_DIM = $clog2(TILE_DIM);
    localparam logic [LOG_DIM:0] LAST = (LOG_DIM + 1)'(TILE_DIM - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    // One spare bit so the counters reach TILE_DIM without aliasing.
    logic [LOG_DIM:0]  tx;
    logic [LOG_DIM:0]  ty;
    logic [ADDR_W-1:0] rowBase;
    logic              idReg;
    logic [ADDR_W-1:0] wrAddr;
    logic [15:0]       wrData;
    logic              doneReg;

    logic acceptStart;
    logic loadPixel;
    logic advance;
    logic lastPixel;
    logic onScreen;

    assign lastPixel = (tx == LAST) && (ty == LAST);

`ifdef TILE_CLIP_EN
    logic [9:0]  xOff;
    logic [9:0]  yOff;
    logic [11:0] scrX;
    logic [11:0] scrY;

    assign scrX     = {2'b00, xOff} + 12'(tx);
    assign scrY     = {2'b00, yOff} + 12'(ty);
    assign onScreen = (scrX < 12'(SCREEN_W)) && (scrY < 12'(SCREEN_H));
`else
    assign onScreen = 1'b1;
`endif

    always_ff @(posedge BOARD_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        acceptStart = 1'b0;
        loadPixel   = 1'b0;
        advance     = 1'b0;
        unique case (state)
            IDLE: begin
                if (startStreaming) begin
                    acceptStart = 1'b1;
                    stateNext   = READ;
                end
            end
            READ: begin
                stateNext = LATCH;
            end
            LATCH: begin
                // Off-screen pixels skip WRITE and never raise a request.
                if (onScreen) begin
                    loadPixel = 1'b1;
                    stateNext = WRITE;
                end else begin
                    advance   = 1'b1;
                    stateNext = lastPixel ? DONE : READ;
                end
            end
            WRITE: begin
                if (sramBus.sramWrAck) begin
                    advance   = 1'b1;
                    stateNext = lastPixel ? DONE : READ;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge BOARD_CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            tx      <= '0;
            ty      <= '0;
            rowBase <= '0;
            idReg   <= 1'b0;
            wrAddr  <= '0;
            wrData  <= '0;
            doneReg <= 1'b1;
`ifdef TILE_CLIP_EN
            xOff    <= '0;
            yOff    <= '0;
`endif
        end else begin
            if (acceptStart) begin
                idReg   <= tileID;
                tx      <= '0;
                ty      <= '0;
                rowBase <= ADDR_W'(yOffset) * ADDR_W'(SCREEN_W)
                         + ADDR_W'(xOffset);
                doneReg <= 1'b0;
`ifdef TILE_CLIP_EN
                xOff    <= xOffset;
                yOff    <= yOffset;
`endif
            end
            // Read data arrives the cycle after READ presents X/Y/Sel.
            if (loadPixel) begin
                wrAddr <= rowBase + ADDR_W'(tx);
                wrData <= tileRdData;
            end
            if (advance) begin
                if (tx == LAST) begin
                    tx      <= '0;
                    ty      <= ty + 1'b1;
                    rowBase <= rowBase + ADDR_W'(SCREEN_W);
                end else begin
                    tx <= tx + 1'b1;
                end
            end
            if (state == DONE) begin
                doneReg <= 1'b1;
            end
        end
    end

    assign doneStreaming      = doneReg;
    assign tileRdSel          = idReg;
    assign tileRdX            = tx[LOG_DIM-1:0];
    assign tileRdY            = ty[LOG_DIM-1:0];
    assign sramBus.sramWrReq  = (state == WRITE);
    assign sramBus.sramWrAddr = wrAddr;
    assign sramBus.sramWrData = wrData;
endmodule

// File: tb/tb_tile_stream_writer.sv
// tb_tile_stream_writer: scoreboard bench for tile_stream_writer.
// Expected writes are queued at start and compared against observed ones.
module tb_tile_stream_writer;
`ifdef TILE_CLIP_EN
    localparam int TD = 64;
`else
    localparam int TD = 32;
`endif
    localparam int LD = $clog2(TD);
    localparam int SW = 640;
    localparam int SH = 480;
    localparam int AW = 20;

    logic          BOARD_CLK = 1'b0;
    logic          Reset_n = 1'b0;
    logic          startStreaming = 1'b0;
    logic          tileID = 1'b0;
    logic [9:0]    xOffset = '0;
    logic [9:0]    yOffset = '0;
    logic          doneStreaming;
    logic          tileRdSel;
    logic [LD-1:0] tileRdX;
    logic [LD-1:0] tileRdY;
    logic [15:0]   tileRdData;

    tile_stream_writer_if #(.ADDR_W(AW)) bus ();

    tile_stream_writer #(
        .TILE_DIM(TD),
        .SCREEN_W(SW),
        .SCREEN_H(SH),
        .ADDR_W(AW)
    ) dut (
        .BOARD_CLK(BOARD_CLK),
        .Reset_n(Reset_n),
        .startStreaming(startStreaming),
        .tileID(tileID),
        .xOffset(xOffset),
        .yOffset(yOffset),
        .doneStreaming(doneStreaming),
        .tileRdSel(tileRdSel),
        .tileRdX(tileRdX),
        .tileRdY(tileRdY),
        .tileRdData(tileRdData),
        .sramBus(bus)
    );

    always #5 BOARD_CLK = ~BOARD_CLK;

    logic [15:0] tileMem [2][TD*TD];

    always @(posedge BOARD_CLK)
        tileRdData <= tileMem[tileRdSel][int'(tileRdY) * TD + int'(tileRdX)];

    int checks = 0;
    int passes = 0;

    logic [35:0]   expQ[$];
    logic [35:0]   obsQ[$];
    logic [35:0]   stallLog[$];
    logic          ackHold = 1'b0;
    int            stallLeft = 0;
    logic [AW-1:0] stallAddr = '1;
    int            reqCycles = 0;
    int            selBad = 0;
    logic          selExp = 1'b0;

    // Ack is decided at the negedge before the edge that would accept it.
    always @(negedge BOARD_CLK) begin
        logic ackNow;
        ackNow = !ackHold;
        if (bus.sramWrReq && bus.sramWrAddr == stallAddr && stallLeft > 0) begin
            ackNow = 1'b0;
            stallLeft--;
            stallLog.push_back({bus.sramWrAddr, bus.sramWrData});
        end
        bus.sramWrAck = ackNow;
        if (bus.sramWrReq) reqCycles++;
        if (bus.sramWrReq && ackNow)
            obsQ.push_back({bus.sramWrAddr, bus.sramWrData});
        if (!doneStreaming && tileRdSel !== selExp) selBad++;
    end

    task automatic push_expected(input int x, input int y, input logic id);
        for (int ty = 0; ty < TD; ty++) begin
            for (int tx = 0; tx < TD; tx++) begin
                int sx;
                int sy;
                logic [AW-1:0] a;
                sx = x + tx;
                sy = y + ty;
`ifdef TILE_CLIP_EN
                if (sx >= SW || sy >= SH) continue;
`endif
                a = AW'(sy * SW + sx);
                expQ.push_back({a, tileMem[id][ty * TD + tx]});
            end
        end
    endtask

    function automatic int score_mismatches();
        int n;
        int m;
        n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
        m = (obsQ.size() > expQ.size()) ? obsQ.size() - expQ.size()
                                        : expQ.size() - obsQ.size();
        for (int i = 0; i < n; i++)
            if (obsQ[i] !== expQ[i]) m++;
        obsQ.delete();
        expQ.delete();
        return m;
    endfunction

    task automatic run_tile(input int x, input int y, input logic id,
                            output int cyc, output bit tout,
                            output logic doneAfterStart);
        push_expected(x, y, id);
        @(negedge BOARD_CLK);
        xOffset = 10'(x);
        yOffset = 10'(y);
        tileID = id;
        startStreaming = 1'b1;
        cyc = 0;
        tout = 1'b1;
        doneAfterStart = 1'bx;
        for (int i = 0; i < 3 * TD * TD + 50; i++) begin
            @(posedge BOARD_CLK);
            #1;
            cyc++;
            if (i == 0) begin
                startStreaming = 1'b0;
                doneAfterStart = doneStreaming;
            end
            if (doneStreaming) begin
                tout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit got;
        repeat (3) @(posedge BOARD_CLK);
        #1;
        checks++;
        if ({bus.sramWrReq, doneStreaming, tileRdSel, tileRdX, tileRdY,
             bus.sramWrAddr, bus.sramWrData} !== {2'b01, 1'b0, (2*LD)'(0),
             AW'(0), 16'h0}) begin
            $display("FAIL reset_state: req=%b done=%b sel=%b x=%0d y=%0d addr=%0d data=%h want 0 1 0 0 0 0 0",
                     bus.sramWrReq, doneStreaming, tileRdSel, tileRdX,
                     tileRdY, bus.sramWrAddr, bus.sramWrData);
        end else passes++;
        @(negedge BOARD_CLK);
        Reset_n = 1'b1;
        ackHold = 1'b1;
        @(negedge BOARD_CLK);
        xOffset = '0;
        yOffset = '0;
        tileID = 1'b1;
        startStreaming = 1'b1;
        @(negedge BOARD_CLK);
        startStreaming = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge BOARD_CLK);
            if (bus.sramWrReq) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1) $display("FAIL reach_write: got %b want 1", got);
        else passes++;
        checks++;
        if (tileRdSel !== 1'b1)
            $display("FAIL sel_latched: got %b want 1", tileRdSel);
        else passes++;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.sramWrReq, doneStreaming, tileRdSel} !== 3'b010)
            $display("FAIL async_reset: req/done/sel got %b want 010",
                     {bus.sramWrReq, doneStreaming, tileRdSel});
        else passes++;
        @(negedge BOARD_CLK);
        Reset_n = 1'b1;
        ackHold = 1'b0;
        obsQ.delete();
        reqCycles = 0;
        repeat (50) @(negedge BOARD_CLK);
        checks++;
        if (reqCycles + obsQ.size() !== 0)
            $display("FAIL no_write_after_reset: got %0d req cycles %0d writes want 0",
                     reqCycles, obsQ.size());
        else passes++;
        checks++;
        if (doneStreaming !== 1'b1)
            $display("FAIL done_after_reset: got %b want 1", doneStreaming);
        else passes++;
        obsQ.delete();
    endtask

    task automatic test_basic();
        int cyc;
        bit tout;
        logic d1;
        int mis;
        selExp = 1'b0;
        selBad = 0;
        run_tile(0, 0, 1'b0, cyc, tout, d1);
        checks++;
        if (tout !== 1'b0) $display("FAIL basic_timeout: got %b want 0", tout);
        else passes++;
        checks++;
        if (d1 !== 1'b0) $display("FAIL basic_done_low: got %b want 0", d1);
        else passes++;
        checks++;
        if (cyc !== 3 * TD * TD + 2)
            $display("FAIL basic_cycles: got %0d want %0d", cyc, 3 * TD * TD + 2);
        else passes++;
        checks++;
        if (obsQ.size() !== TD * TD)
            $display("FAIL basic_count: got %0d want %0d", obsQ.size(), TD * TD);
        else passes++;
        checks++;
        if (obsQ[TD][35:16] !== AW'(SW))
            $display("FAIL basic_row1_addr: got %0d want %0d", obsQ[TD][35:16], SW);
        else passes++;
        checks++;
        if (obsQ[TD*TD-1][35:16] !== AW'((TD - 1) * SW + TD - 1))
            $display("FAIL basic_last_addr: got %0d want %0d",
                     obsQ[TD*TD-1][35:16], (TD - 1) * SW + TD - 1);
        else passes++;
        checks++;
        if (selBad !== 0) $display("FAIL basic_sel: got %0d bad cycles want 0", selBad);
        else passes++;
        mis = score_mismatches();
        checks++;
        if (mis !== 0) $display("FAIL basic_scoreboard: got %0d mismatches want 0", mis);
        else passes++;
    endtask

    task automatic test_offset();
        int cyc;
        bit tout;
        logic d1;
        int mis;
        selExp = 1'b1;
        selBad = 0;
        run_tile(608, 448, 1'b1, cyc, tout, d1);
        checks++;
        if (tout !== 1'b0) $display("FAIL offset_timeout: got %b want 0", tout);
        else passes++;
        checks++;
        if (obsQ.size() !== 1024)
            $display("FAIL offset_count: got %0d want 1024", obsQ.size());
        else passes++;
        checks++;
        if (obsQ[0][35:16] !== 20'd287328)
            $display("FAIL offset_first_addr: got %0d want 287328", obsQ[0][35:16]);
        else passes++;
        checks++;
        if (obsQ[1023][35:16] !== 20'd307199)
            $display("FAIL offset_last_addr: got %0d want 307199", obsQ[1023][35:16]);
        else passes++;
        checks++;
        if (selBad !== 0) $display("FAIL offset_sel: got %0d bad cycles want 0", selBad);
        else passes++;
        mis = score_mismatches();
        checks++;
        if (mis !== 0) $display("FAIL offset_scoreboard: got %0d mismatches want 0", mis);
        else passes++;
        selExp = 1'b0;
    endtask

    task automatic test_stall();
        int cyc;
        bit tout;
        logic d1;
        int mis;
        int hits;
        int idx;
        int bad;
        logic [35:0] want;
        want = {20'd1283, tileMem[0][2 * TD + 3]};
        stallLog.delete();
        stallAddr = 20'd1283;
        stallLeft = 5;
        run_tile(0, 0, 1'b0, cyc, tout, d1);
        stallAddr = '1;
        checks++;
        if (cyc !== 3 * TD * TD + 7 || tout !== 1'b0)
            $display("FAIL stall_cycles: got %0d timeout %b want %0d",
                     cyc, tout, 3 * TD * TD + 7);
        else passes++;
        bad = 0;
        foreach (stallLog[i]) if (stallLog[i] !== want) bad++;
        checks++;
        if (stallLog.size() !== 5 || bad !== 0)
            $display("FAIL stall_hold: got %0d held cycles %0d unstable want 5 0",
                     stallLog.size(), bad);
        else passes++;
        hits = 0;
        idx = -1;
        foreach (obsQ[i]) begin
            if (obsQ[i][35:16] == 20'd1283) begin
                hits++;
                idx = i;
            end
        end
        checks++;
        if (hits !== 1) $display("FAIL stall_single_write: got %0d want 1", hits);
        else passes++;
        checks++;
        if (idx < 0 || obsQ[idx+1][35:16] !== 20'd1284)
            $display("FAIL stall_next_pixel: got idx %0d want addr 1284 next", idx);
        else passes++;
        mis = score_mismatches();
        checks++;
        if (mis !== 0) $display("FAIL stall_scoreboard: got %0d mismatches want 0", mis);
        else passes++;
    endtask

    task automatic test_busy_start();
        bit tout;
        int mis;
        selExp = 1'b0;
        selBad = 0;
        push_expected(0, 0, 1'b0);
        @(negedge BOARD_CLK);
        xOffset = '0;
        yOffset = '0;
        tileID = 1'b0;
        startStreaming = 1'b1;
        @(posedge BOARD_CLK);
        #1;
        startStreaming = 1'b0;
        repeat (100) @(negedge BOARD_CLK);
        xOffset = 10'd100;
        yOffset = 10'd100;
        tileID = 1'b1;
        startStreaming = 1'b1;
        repeat (3) @(negedge BOARD_CLK);
        startStreaming = 1'b0;
        tout = 1'b1;
        for (int i = 0; i < 3 * TD * TD + 50; i++) begin
            @(posedge BOARD_CLK);
            #1;
            if (doneStreaming) begin
                tout = 1'b0;
                break;
            end
        end
        checks++;
        if (tout !== 1'b0) $display("FAIL busy_timeout: got %b want 0", tout);
        else passes++;
        checks++;
        if (obsQ.size() !== TD * TD)
            $display("FAIL busy_count: got %0d want %0d", obsQ.size(), TD * TD);
        else passes++;
        checks++;
        if (selBad !== 0) $display("FAIL busy_sel: got %0d bad cycles want 0", selBad);
        else passes++;
        mis = score_mismatches();
        checks++;
        if (mis !== 0) $display("FAIL busy_scoreboard: got %0d mismatches want 0", mis);
        else passes++;
        reqCycles = 0;
        repeat (100) @(negedge BOARD_CLK);
        checks++;
        if (reqCycles !== 0 || doneStreaming !== 1'b1)
            $display("FAIL busy_no_second_tile: got %0d req cycles done %b want 0 1",
                     reqCycles, doneStreaming);
        else passes++;
    endtask

`ifdef TILE_CLIP_EN
    task automatic test_clip();
        int cyc;
        bit tout;
        logic d1;
        int mis;
        run_tile(576, 448, 1'b0, cyc, tout, d1);
        checks++;
        if (tout !== 1'b0) $display("FAIL clip_timeout: got %b want 0", tout);
        else passes++;
        checks++;
        if (obsQ.size() !== 2048)
            $display("FAIL clip_count: got %0d want 2048", obsQ.size());
        else passes++;
        checks++;
        if (obsQ[0][35:16] !== 20'd287296)
            $display("FAIL clip_first_addr: got %0d want 287296", obsQ[0][35:16]);
        else passes++;
        checks++;
        if (obsQ[2047][35:16] !== 20'd307199)
            $display("FAIL clip_last_addr: got %0d want 307199", obsQ[2047][35:16]);
        else passes++;
        mis = score_mismatches();
        checks++;
        if (mis !== 0) $display("FAIL clip_scoreboard: got %0d mismatches want 0", mis);
        else passes++;
    endtask
`endif

    initial begin
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < TD * TD; i++)
                tileMem[s][i] = 16'($urandom);
        test_reset();
        test_basic();
        test_offset();
        test_stall();
        test_busy_start();
`ifdef TILE_CLIP_EN
        test_clip();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
